// File: rtl/multilane_rx_buffer_if.sv
// multilane_rx_buffer_if: per-lane serial input, pop request and FIFO status bundle
interface multilane_rx_buffer_if #(
  parameter int LANES = 2,
  parameter int DATA_SIZE = 8
);
  logic [LANES-1:0] in, read, valid, active, almost_full, empty, error;
  logic [LANES*DATA_SIZE-1:0] out;
  modport master (output in, read, input out, valid, active, almost_full, empty, error);
  modport slave (input in, read, output out, valid, active, almost_full, empty, error);
endinterface

// File: rtl/multilane_rx_buffer.sv
// multilane_rx_buffer: per-lane deserialiser with comma lock, comma stripping and FIFO
module multilane_rx_buffer #(
  parameter int LANES = 2,
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 2,
  parameter logic [DATA_SIZE-1:0] COMMA = 8'hBC,
  parameter int ACTIVE_COUNT = 4,
  parameter int AF_MARGIN = 1
) (
  input logic clk8f,
  input logic reset,
  multilane_rx_buffer_if.slave b
);
  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam int BW = $clog2(DATA_SIZE);
  localparam int CW = $clog2(ACTIVE_COUNT + 1);
  localparam logic [ADDR_SIZE:0] FULL_CNT = (ADDR_SIZE + 1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] AF_TH = (ADDR_SIZE + 1)'(DEPTH - AF_MARGIN);
  typedef enum logic {SEARCH, ACTIVE} state_e;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic wc;
  logic [DATA_SIZE-1:0] out_q [LANES];
  logic valid_q [LANES];
  logic err_q [LANES];
  state_e state_q [LANES];
  logic [ADDR_SIZE:0] wr_q [LANES];
  logic [ADDR_SIZE:0] rd_q [LANES];
  // one bit counter serves all lanes since every byte boundary is fixed by reset
  always_comb begin
    wc = bitcnt_q == BW'(DATA_SIZE - 1);
    bitcnt_d = wc ? '0 : bitcnt_q + 1'b1;
  end
  // bit counter register
  always_ff @(posedge clk8f) bitcnt_q <= reset ? '0 : bitcnt_d;
  // drive outputs; status flags come straight from the registered pointers
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      b.out[k*DATA_SIZE +: DATA_SIZE] = out_q[k];
      b.valid[k] = valid_q[k];
      b.error[k] = err_q[k];
      b.active[k] = state_q[k] == ACTIVE;
      b.empty[k] = wr_q[k] == rd_q[k];
      b.almost_full[k] = (wr_q[k] - rd_q[k]) >= AF_TH;
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_SIZE-2:0] shift_q;
    logic [DATA_SIZE-1:0] shift_d, out_d;
    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [DATA_SIZE-1:0] mem_d [DEPTH];
    logic [ADDR_SIZE:0] wr_d, rd_d, count;
    logic [CW-1:0] ccnt_q, ccnt_d;
    state_e state_d;
    logic valid_d, err_d, comma, push_req, push, pop, full, lock;
    // assemble the word, track comma lock and decide push/pop for this edge
    always_comb begin
      shift_d = {shift_q, b.in[i]};
      comma = shift_d == COMMA;
      count = wr_q[i] - rd_q[i];
      full = count == FULL_CNT;
      push_req = wc && state_q[i] == ACTIVE && !comma;
      pop = b.read[i] && count != '0;
      push = push_req && (!full || pop);
      lock = wc && state_q[i] == SEARCH && comma && (ccnt_q + 1'b1) == CW'(ACTIVE_COUNT);
      ccnt_d = (wc && state_q[i] == SEARCH) ? (comma ? ccnt_q + 1'b1 : '0) : ccnt_q;
      state_d = lock ? ACTIVE : state_q[i];
      wr_d = push ? wr_q[i] + 1'b1 : wr_q[i];
      rd_d = pop ? rd_q[i] + 1'b1 : rd_q[i];
      mem_d = mem_q;
      if (push) mem_d[wr_q[i][ADDR_SIZE-1:0]] = shift_d;
      out_d = pop ? mem_q[rd_q[i][ADDR_SIZE-1:0]] : out_q[i];
      valid_d = pop;
      err_d = err_q[i] | (push_req & full & !pop) | (b.read[i] & (count == '0));
    end
    // lane registers; storage needs no reset because the pointers define its contents
    always_ff @(posedge clk8f) begin
      mem_q <= mem_d;
      if (reset) begin
        shift_q <= '0;
        ccnt_q <= '0;
        state_q[i] <= SEARCH;
        wr_q[i] <= '0;
        rd_q[i] <= '0;
        out_q[i] <= '0;
        valid_q[i] <= 1'b0;
        err_q[i] <= 1'b0;
      end else begin
        shift_q <= shift_d[DATA_SIZE-2:0];
        ccnt_q <= ccnt_d;
        state_q[i] <= state_d;
        wr_q[i] <= wr_d;
        rd_q[i] <= rd_d;
        out_q[i] <= out_d;
        valid_q[i] <= valid_d;
        err_q[i] <= err_d;
      end
    end
  end
endmodule

// File: tb/tb_multilane_rx_buffer.sv
// tb_multilane_rx_buffer: directed and random checks against a word/queue level lane model
module tb_multilane_rx_buffer;
  localparam logic [7:0] BC = 8'hBC;
  localparam int DEPTH = 4;
  localparam int LOCK_N = 4;
  localparam int AF_LEVEL = 3;
  logic clk8f = 1'b0;
  logic reset = 1'b1;
  int n_assert = 0;
  int n_fail = 0;
  int pos;
  logic [7:0] acc [2];
  int ccnt [2];
  bit locked [2];
  logic [7:0] q [2][$];
  logic [7:0] m_out [2];
  bit m_valid [2];
  bit m_err [2];

  always #5 clk8f = ~clk8f;

  multilane_rx_buffer_if #(.LANES(2), .DATA_SIZE(8)) bus ();

  multilane_rx_buffer #(
    .LANES(2), .DATA_SIZE(8), .ADDR_SIZE(2), .COMMA(8'hBC), .ACTIVE_COUNT(4), .AF_MARGIN(1)
  ) dut (
    .clk8f(clk8f),
    .reset(reset),
    .b(bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pos = 0;
    for (int l = 0; l < 2; l++) begin
      acc[l] = 8'h00;
      ccnt[l] = 0;
      locked[l] = 1'b0;
      q[l].delete();
      m_out[l] = 8'h00;
      m_valid[l] = 1'b0;
      m_err[l] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [1:0] bits, input logic [1:0] rd);
    for (int l = 0; l < 2; l++) begin
      logic [7:0] w;
      w = {acc[l][6:0], bits[l]};
      acc[l] = w;
      m_valid[l] = 1'b0;
      if (rd[l]) begin
        if (q[l].size() > 0) begin
          m_out[l] = q[l].pop_front();
          m_valid[l] = 1'b1;
        end else m_err[l] = 1'b1;
      end
      if (pos == 7) begin
        if (!locked[l]) begin
          ccnt[l] = (w == BC) ? ccnt[l] + 1 : 0;
          if (ccnt[l] == LOCK_N) locked[l] = 1'b1;
        end else if (w != BC) begin
          if (q[l].size() < DEPTH) q[l].push_back(w);
          else m_err[l] = 1'b1;
        end
      end
    end
    pos = (pos + 1) % 8;
  endtask

  task automatic check_all();
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("out%0d", l), bus.out[l*8 +: 8], m_out[l]);
      chk($sformatf("valid%0d", l), bus.valid[l], m_valid[l]);
      chk($sformatf("active%0d", l), bus.active[l], locked[l]);
      chk($sformatf("empty%0d", l), bus.empty[l], q[l].size() == 0);
      chk($sformatf("almost_full%0d", l), bus.almost_full[l], q[l].size() >= AF_LEVEL);
      chk($sformatf("error%0d", l), bus.error[l], m_err[l]);
    end
  endtask

  task automatic tick(input logic [1:0] bits, input logic [1:0] rd, input bit rst = 1'b0);
    bus.in = bits;
    bus.read = rd;
    reset = rst;
    @(posedge clk8f);
    if (rst) model_reset();
    else model_step(bits, rd);
    #1 check_all();
  endtask

  task automatic send(input logic [7:0] w0, input logic [7:0] w1, input logic [1:0] rd = 2'b00,
                      input int rpos = 0);
    for (int k = 7; k >= 0; k--) tick({w1[k], w0[k]}, (7 - k) == rpos ? rd : 2'b00);
  endtask

  initial begin
    bus.in = 2'b00;
    bus.read = 2'b00;
    model_reset();
    tick(2'b00, 2'b00, 1'b1);
    tick(2'b00, 2'b00, 1'b1);
    chk("rst_empty", bus.empty, 2'b11);
    chk("rst_out", bus.out, 16'h0000);
    // lock lane 0; lane 1 is broken by 0x55
    send(BC, BC);
    send(BC, BC);
    send(BC, BC);
    send(BC, 8'h55);
    chk("lock", bus.active, 2'b01);
    // data path
    send(8'hA5, BC);
    chk("dp_not_empty", bus.empty[0], 1'b0);
    send(8'h3C, 8'h00);
    send(BC, BC, 2'b01, 0);
    chk("dp_rd1", bus.out[7:0], 8'hA5);
    send(BC, BC, 2'b01, 0);
    chk("dp_rd2", bus.out[7:0], 8'h3C);
    chk("dp_empty", bus.empty[0], 1'b1);
    // comma stripping; lane 1 locks during these words
    send(8'h11, BC);
    send(BC, BC);
    send(8'h22, BC);
    send(BC, BC, 2'b01, 0);
    chk("strip_rd1", bus.out[7:0], 8'h11);
    send(BC, BC, 2'b01, 0);
    chk("strip_rd2", bus.out[7:0], 8'h22);
    chk("strip_empty", bus.empty[0], 1'b1);
    chk("lock_both", bus.active, 2'b11);
    // overflow on lane 1
    send(BC, 8'h01);
    send(BC, 8'h02);
    send(BC, 8'h03);
    chk("ovf_af", bus.almost_full[1], 1'b1);
    send(BC, 8'h04);
    send(BC, 8'h05);
    chk("ovf_err", bus.error, 2'b10);
    for (int n = 1; n <= 4; n++) begin
      send(BC, BC, 2'b10, 0);
      chk("ovf_rd", bus.out[15:8], 8'(n));
    end
    chk("ovf_lane0_err", bus.error[0], 1'b0);
    // full lane 0: push and pop on the same edge
    send(8'h61, BC);
    send(8'h62, BC);
    send(8'h63, BC);
    send(8'h64, BC);
    send(8'h65, BC, 2'b01, 7);
    chk("sim_err", bus.error[0], 1'b0);
    chk("sim_af", bus.almost_full[0], 1'b1);
    chk("sim_out", bus.out[7:0], 8'h61);
    for (int n = 2; n <= 5; n++) begin
      send(BC, BC, 2'b01, 0);
      chk("sim_drain", bus.out[7:0], 8'h60 + 8'(n));
    end
    // underflow
    send(BC, BC, 2'b01, 0);
    chk("udf_err", bus.error[0], 1'b1);
    // reset mid-stream with two words queued on lane 1
    send(BC, 8'h71);
    send(BC, 8'h72);
    tick(2'b11, 2'b00);
    tick(2'b01, 2'b00);
    tick(2'b00, 2'b00, 1'b1);
    chk("mrst_empty", bus.empty, 2'b11);
    chk("mrst_active", bus.active, 2'b00);
    chk("mrst_error", bus.error, 2'b00);
    chk("mrst_out", bus.out, 16'h0000);
    send(8'h99, 8'h99);
    chk("mrst_nolock", bus.empty, 2'b11);
    for (int n = 0; n < 4; n++) send(BC, BC);
    chk("relock", bus.active, 2'b11);
    // random traffic: slow reads then fast reads
    for (int n = 0; n < 240; n++) begin
      logic [7:0] w0, w1;
      int r;
      w0 = ($urandom_range(0, 3) == 0) ? BC : 8'($urandom);
      w1 = ($urandom_range(0, 3) == 0) ? BC : 8'($urandom);
      r = (n < 120) ? 15 : 3;
      for (int k = 7; k >= 0; k--)
        tick({w1[k], w0[k]}, {$urandom_range(0, r) == 0, $urandom_range(0, r) == 0});
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
